// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and FSM state encoding shared by the ALU request scheduler.
package alu_pkg;
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_ZERO = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; ties go to the requester equal to prio.
// Ports: req[1:0] requests, prio tie-break winner, en arbitration enable,
//        gnt[1:0] one-hot grant, id index of the granted requester.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       id
);
    assign gnt[0] = en & req[0] & (~req[1] | ~prio);
    assign gnt[1] = en & req[1] & (~req[0] | prio);
    assign id     = gnt[1];
endmodule

// File: rtl/alu_req_sched.sv
// alu_req_sched: shares one combinational ALU between two requesters with round-robin
// arbitration, operand latching, a multi-cycle MUL window and a tagged response.
// Ports: clk/rst_n clock and async active-low reset; req0_*/req1_* command channels
//        (valid/ready, a, b, op); alu_a/alu_b/alu_sel drive the ALU and alu_r/alu_z
//        return its result; rsp_* is the valid/ready response (id, result, zero);
//        busy is high whenever a command is in flight.
import alu_pkg::*;

module alu_req_sched #(
    parameter int W          = 32,
    parameter int MUL_CYCLES = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [2:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [2:0]   req1_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_sel,
    input  logic [W-1:0] alu_r,
    input  logic         alu_z,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_r,
    output logic         rsp_z,
    output logic         busy
);
    state_t     state;
    logic       prio;
    logic [3:0] cnt;
    logic [1:0] gnt;
    logic       gnt_id;
    logic [2:0] gnt_op;

    rr_arb2 u_arb (
        .req  ({req1_valid, req0_valid}),
        .prio (prio),
        .en   (state == IDLE),
        .gnt  (gnt),
        .id   (gnt_id)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign busy       = state != IDLE;
    assign gnt_op     = gnt_id ? req1_op : req0_op;

    // The latches double as the ALU drive, so the ALU inputs never toggle between operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prio      <= 1'b0;
            cnt       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            rsp_id    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_r     <= '0;
            rsp_z     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|gnt) begin
                    alu_a   <= gnt_id ? req1_a : req0_a;
                    alu_b   <= gnt_id ? req1_b : req0_b;
                    alu_sel <= gnt_op;
                    rsp_id  <= gnt_id;
                    cnt     <= (gnt_op == OP_MUL) ? 4'(MUL_CYCLES - 1) : 4'd0;
                    state   <= EXEC;
                end
                EXEC: if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    rsp_r     <= alu_r;
                    rsp_z     <= alu_z;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    prio      <= ~rsp_id;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_req_sched.sv
// tb_alu_req_sched: directed, table-driven check of alu_req_sched against a behavioural ALU.
module tb_alu_req_sched;
    localparam int W = 32;
    localparam int MUL_CYCLES = 3;

    logic         clk = 0, rst_n = 0;
    logic         req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
    logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [2:0]   req0_op = 0, req1_op = 0;
    logic [W-1:0] alu_a, alu_b, alu_r, rsp_r;
    logic [2:0]   alu_sel;
    logic         alu_z, rsp_valid, rsp_ready = 0, rsp_id, rsp_z, busy;

    int nvec = 0, nerr = 0;

    alu_req_sched #(.W(W), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_r(alu_r), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_r(rsp_r), .rsp_z(rsp_z),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the external combinational alub.
    always_comb begin
        case (alu_sel)
            3'b001:  alu_r = alu_a + alu_b;
            3'b010:  alu_r = alu_a & alu_b;
            3'b011:  alu_r = alu_a | alu_b;
            3'b100:  alu_r = alu_a * alu_b;
            3'b101:  alu_r = alu_a - alu_b;
            3'b110:  alu_r = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_r = '0;
        endcase
        alu_z = alu_r == '0;
    end

    typedef struct {
        logic        id;
        logic [31:0] a, b;
        logic [2:0]  op;
        logic [31:0] r;
        logic        z;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input logic id, input logic v, input logic [31:0] a, b, input logic [2:0] op);
        if (id) begin req1_valid = v; req1_a = a; req1_b = b; req1_op = op; end
        else    begin req0_valid = v; req0_a = a; req0_b = b; req0_op = op; end
    endtask

    // Present a command, wait (bounded) for ready, return #1 after the accept edge.
    task automatic issue(input logic id, input logic [31:0] a, b, input logic [2:0] op);
        int n = 0;
        set_req(id, 1'b1, a, b, op);
        #1;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("grant", id ? req1_ready : req0_ready, 1);
        @(posedge clk); #1;
        set_req(id, 1'b0, 32'd0, 32'd0, 3'd0);
    endtask

    // Called #1 after the accept edge; checks operand hold, latency, response and retirement.
    task automatic wait_rsp(input logic id, input logic [31:0] a, b, input logic [2:0] op,
                            input logic [31:0] r, input logic z);
        int lat = 0;
        chk("alu_hold", {alu_sel, alu_a[14:0], alu_b[13:0]}, {op, a[14:0], b[13:0]});
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
            chk("alu_sel_hold", alu_sel, op);
        end
        // rsp_valid rises one edge before the "visible from" edge: T+1 for ALU ops, T+MUL_CYCLES for MUL.
        chk("latency", lat, (op == 3'b100) ? MUL_CYCLES : 1);
        chk("rsp_r", rsp_r, r);
        chk("rsp_z", rsp_z, z);
        chk("rsp_id", rsp_id, id);
        if (rsp_ready) begin
            @(posedge clk); #1;
            chk("rsp_valid_drop", rsp_valid, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        int got;
        vecs[0] = '{0, 32'h10,    32'h20,    3'b001, 32'h30,       0};
        vecs[1] = '{1, 32'd4,     32'd5,     3'b100, 32'd20,       0};
        vecs[2] = '{0, 32'hF,     32'hFFF,   3'b111, 32'h0,        1};
        vecs[3] = '{1, 32'h8,     32'hF0,    3'b010, 32'h0,        1};
        vecs[4] = '{0, 32'h10,    32'h5,     3'b101, 32'hB,        0};
        vecs[5] = '{1, 32'd5,     32'h10,    3'b110, 32'd1,        0};
        vecs[6] = '{0, 32'hF0,    32'h0F,    3'b011, 32'hFF,       0};
        vecs[7] = '{1, 32'd7,     32'd9,     3'b000, 32'h0,        1};
        vecs[8] = '{0, 32'h10000, 32'h10000, 3'b100, 32'h0,        1};
        vecs[9] = '{1, 32'd0,     32'd1,     3'b101, 32'hFFFFFFFF, 0};

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu", {alu_a, alu_b[28:0], alu_sel}, 0);
        chk("rst_rsp", {rsp_r[30:0], rsp_z, rsp_id}, 0);
        chk("rst_ready", {req0_ready, req1_ready}, 0);
        rst_n = 1;
        rsp_ready = 1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op);
            wait_rsp(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].r, vecs[i].z);
            chk("idle_after", busy, 0);
        end

        // Back-pressure: response held while a new request waits.
        @(negedge clk);
        rsp_ready = 0;
        issue(0, 32'd1, 32'hF, 3'b010);
        set_req(1, 1'b1, 32'd3, 32'd4, 3'b011);
        got = 0;
        while (!rsp_valid && got < 20) begin @(posedge clk); #1; got++; end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_r", rsp_r, 1);
            chk("bp_z", rsp_z, 0);
            chk("bp_busy_ready", {busy, req0_ready, req1_ready}, 3'b100);
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        chk("bp_retire", {rsp_valid, busy, req1_ready}, 3'b001);
        @(posedge clk); #1;
        set_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
        wait_rsp(1, 32'd3, 32'd4, 3'b011, 32'd7, 0);

        // Reset during the second EXEC cycle of a MUL.
        @(negedge clk);
        issue(0, 32'd6, 32'd7, 3'b100);
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst_n = 1;

        // Contention after reset: grants alternate starting with requester 0.
        set_req(0, 1'b1, 32'h10, 32'h5, 3'b101);
        set_req(1, 1'b1, 32'd5, 32'h10, 3'b110);
        #1;
        chk("post_rst_grant", {req1_ready, req0_ready}, 2'b01);
        got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin
                chk("rr_id", rsp_id, got % 2);
                chk("rr_r", rsp_r, (got % 2) ? 32'd1 : 32'hB);
                got++;
            end
        end
        chk("rr_count", got, 4);
        @(negedge clk);
        set_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
        set_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
        repeat (4) @(negedge clk);
        chk("final_idle", {busy, rsp_valid}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/alu_req_sched.md
Name: alu_req_sched

Overview:
- Schedules shared access to the single 32-bit ALU (`alub`) between two requesters.
- Arbitrates round-robin and latches the granted operands and opcode.
- Holds the ALU inputs stable for the operation's execution time. Multiply gets a configurable multi-cycle window.
- Returns the registered result and zero flag, tagged with the requester ID, over a valid/ready response channel.
- Sits between the command sources and the `alub` instance, which stays combinational and external.

Parameters:
- W, 32, operand and result width. Must match the ALU.
- MUL_CYCLES, 3, cycles the ALU inputs are held for opcode MUL (3'b100). Range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a command.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_a  in  W  requester 0 operand A.
- req0_b  in  W  requester 0 operand B.
- req0_op  in  3  requester 0 ALU select.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- alu_a  out  W  to ALU A.
- alu_b  out  W  to ALU B.
- alu_sel  out  3  to ALU sel.
- alu_r  in  W  ALU result.
- alu_z  in  1  ALU zero flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester that issued the command.
- rsp_r  out  W  registered result.
- rsp_z  out  1  registered zero flag.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, prio=0, all latches 0, rsp_valid=0, rsp_id=0, rsp_r=0, rsp_z=0. As a result alu_a=0, alu_b=0, alu_sel=0, req*_ready=0, busy=0.
- FSM state IDLE:
  - reqN_ready = grant_N (combinational).
  - Grant rule: if only one valid, grant it. If both are valid, grant the requester equal to prio.
  - On the grant edge, latch a, b, op and id.
  - Load cnt = MUL_CYCLES-1 if op==3'b100, else 0.
  - Go to EXEC.
  - No grant: stay in IDLE.
- FSM state EXEC:
  - alu_a, alu_b and alu_sel are driven from the latches, stable for the whole window.
  - cnt != 0: decrement.
  - cnt == 0: capture alu_r and alu_z into rsp_r and rsp_z, go to RESP.
- FSM state RESP:
  - rsp_valid=1. rsp_r, rsp_z and rsp_id are held stable until handshake.
  - On rsp_ready: prio <= ~id and go to IDLE.
  - rsp_valid drops on the following cycle.
- ALU drive outside EXEC: alu_a, alu_b and alu_sel keep their latched values (no toggling). They are 0 only after reset.
- Latency:
  - Accept at edge T. Non-MUL: rsp_valid high from T+2. MUL: rsp_valid high from T+1+MUL_CYCLES.
  - Minimum issue interval is 3 cycles. No command is accepted in EXEC or RESP.
- Opcodes: all 8 sel values are passed through unmodified. 3'b000 and 3'b111 execute normally; the ALU returns 0 and Z=1 for them. No opcode is rejected.
- Requester protocol:
  - A requester holds valid, a, b and op until ready.
  - The scheduler samples only on the grant cycle, so later changes are ignored.
  - A requester with valid low is never granted.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,…
  - Granted-requester sequence: requester 0 first out of reset, then requester 1.
  - A lone requester may be granted repeatedly.
- Reset mid-operation:
  - Immediate return to IDLE. Any in-flight response is discarded and rsp_valid drops asynchronously.
  - prio returns to 0.
- Simultaneous events:
  - rsp_ready arriving with new req valid in RESP: the response completes, and the new request is granted in the next cycle (IDLE).
  - rsp_ready while rsp_valid=0: ignored.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams: OP_NOP=000, OP_ADD=001, OP_AND=010, OP_OR=011, OP_MUL=100, OP_SUB=101, OP_SLT=110, OP_ZERO=111.
  - FSM state encoding: IDLE, EXEC, RESP.
- Sub-module rr_arb2:
  - Inputs: two requests, prio, enable.
  - Outputs: one-hot grant plus granted id.
- The FSM, counter and latches stay in alu_req_sched.

Test Plan:
- Single add: req0 a=0x10, b=0x20, op=001 accepted at T, rsp_ready=1 → rsp_valid at T+2, rsp_r=0x30, rsp_z=0, rsp_id=0.
- Multiply latency: req1 a=4, b=5, op=100, MUL_CYCLES=3 → alu_sel=100 held for 3 cycles, rsp_valid at T+4, rsp_r=20, rsp_id=1.
- Contention and fairness: both valid continuously. req0 is SUB 0x10-0x5 and req1 is SLT 5<0x10 → results in order 0xB (id 0), 1 (id 1), 0xB (id 0); never two consecutive grants to one requester while both are valid.
- Back-pressure: AND 1&0xF completes with rsp_ready=0 for 5 cycles → rsp_valid, rsp_r=1 and rsp_z stay stable; req_ready stays 0 and busy=1. When rsp_ready rises, response retired; next grant in the following cycle.
- Default and zero flag: op=111, a=0xF, b=0xFFF → rsp_r=0, rsp_z=1. Then op=010, a=0x8, b=0xF0 → rsp_r=0, rsp_z=1.
- Reset mid-MUL: rst_n low during EXEC cycle 2 → busy=0 and rsp_valid=0 immediately, no response emitted. After release, a simultaneous req0 and req1 grants req0 first.
